// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between the CPU load/store path and the VGA reader.
// VGA wins ties; a saturating starvation counter forces a CPU slot after STARVE_MAX VGA grants.
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_vga
);

  // state | meaning
  // IDLE  | arbitrate between cpu_req and vga_req
  // ISSUE | one-cycle memory strobe for the latched owner
  // WAIT  | RD_LAT cycles of read latency; capture on the last one
  // ACK   | one-cycle ack pulse to the owner, then mandatory return to IDLE
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int LW = 2;

  state_t            state, state_nxt;
  logic [SW-1:0]     starve_cnt;
  logic [LW-1:0]     lat_cnt;
  logic              owner_vga, owner_we;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              grant, pick_vga, starved, lat_done;

  assign starved  = (starve_cnt == SW'(STARVE_MAX));
  assign lat_done = (lat_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    pick_vga  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    cpu_ack   = 1'b0;
    vga_ack   = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (vga_req || cpu_req) begin
          grant     = 1'b1;
          pick_vga  = vga_req && !(cpu_req && starved);
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        mem_en    = 1'b1;
        mem_we    = owner_we;
        state_nxt = owner_we ? ACK : WAIT;
      end
      WAIT: begin
        if (lat_done) state_nxt = ACK;
      end
      ACK: begin
        cpu_ack   = !owner_vga;
        vga_ack   = owner_vga;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
      lat_cnt    <= '0;
      owner_vga  <= 1'b0;
      owner_we   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cpu_rdata  <= '0;
      vga_rdata  <= '0;
    end else begin
      if (grant) begin
        owner_vga <= pick_vga;
        owner_we  <= !pick_vga && cpu_we;
        addr_q    <= pick_vga ? vga_addr : cpu_addr;
        wdata_q   <= pick_vga ? '0 : cpu_wdata;
        // Only VGA grants that bypass a waiting CPU count toward starvation.
        if (pick_vga && cpu_req)
          starve_cnt <= starved ? starve_cnt : starve_cnt + SW'(1);
        else
          starve_cnt <= '0;
      end
      if (state == ISSUE)
        lat_cnt <= LW'(RD_LAT - 1);
      else if (state == WAIT && !lat_done)
        lat_cnt <= lat_cnt - LW'(1);
      if (state == WAIT && lat_done) begin
        if (owner_vga) vga_rdata <= mem_rdata;
        else           cpu_rdata <= mem_rdata;
      end
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign grant_vga = owner_vga;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter with a behavioural memory and
// an access-level reference model (arbitration rule, starvation count, latency, data).
module tb_mem_port_arbiter;
  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;
  localparam int RD_LAT     = 2;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, vga_req;
  logic [15:0] cpu_addr, cpu_wdata, vga_addr;
  logic [15:0] cpu_rdata, vga_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_ack, vga_ack, mem_en, mem_we, busy, grant_vga;

  int checks = 0;
  int errors = 0;
  int starve_m = 0;
  logic [15:0] cpu_rd_m, vga_rd_m;
  logic [15:0] mem [logic [15:0]];
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] pipe [0:2];

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_rdata(vga_rdata), .vga_ack(vga_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .grant_vga(grant_vga)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a == 16'h0123) ? 16'h1234 : (a ^ 16'h5A5A);
  endfunction

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [15:0] pick_addr();
    return ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
  endfunction

  // Memory macro: stores what the DUT writes; read data appears RD_LAT cycles after issue,
  // garbage at all other times so mistimed captures show up.
  always @(negedge clk) begin
    logic [15:0] rd;
    rd = 16'($urandom);
    if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
    else if (mem_en) rd = mem.exists(mem_addr) ? mem[mem_addr] : init_val(mem_addr);
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = rd;
  end

  always @(posedge clk) begin
    #1 mem_rdata = pipe[RD_LAT-1];
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at the negedge of an IDLE cycle with requests already driven; walks one full
  // access and leaves the bench at the negedge of the following IDLE cycle.
  task automatic access(input bit drop);
    bit          exp_v, own_we;
    logic [15:0] a, d, rd;
    exp_v = vga_req && !(cpu_req && starve_m >= STARVE_MAX);
    if (exp_v && cpu_req) starve_m = (starve_m < STARVE_MAX) ? starve_m + 1 : STARVE_MAX;
    else                  starve_m = 0;
    own_we = !exp_v && cpu_we;
    a = exp_v ? vga_addr : cpu_addr;
    d = exp_v ? 16'h0000 : cpu_wdata;
    chk1("idle_busy", busy, 1'b0);
    @(negedge clk);
    chk1("issue_en", mem_en, 1'b1);
    chk1("issue_we", mem_we, own_we);
    chk16("issue_addr", mem_addr, a);
    chk16("issue_wdata", mem_wdata, d);
    chk1("issue_owner", grant_vga, exp_v);
    chk1("issue_busy", busy, 1'b1);
    if (own_we) ref_mem[a] = d;
    else begin
      repeat (RD_LAT) begin
        @(negedge clk);
        chk1("wait_en", mem_en, 1'b0);
        chk16("wait_addr", mem_addr, a);
        chk1("wait_ack", cpu_ack | vga_ack, 1'b0);
      end
    end
    @(negedge clk);
    chk1("ack_cpu", cpu_ack, !exp_v);
    chk1("ack_vga", vga_ack, exp_v);
    chk1("ack_en", mem_en, 1'b0);
    if (!own_we) begin
      rd = ref_rd(a);
      if (exp_v) vga_rd_m = rd;
      else       cpu_rd_m = rd;
    end
    chk16("cpu_rdata", cpu_rdata, cpu_rd_m);
    chk16("vga_rdata", vga_rdata, vga_rd_m);
    if (drop) begin
      if (exp_v) vga_req = 1'b0;
      else       cpu_req = 1'b0;
    end
    @(negedge clk);
    chk1("post_busy", busy, 1'b0);
    chk1("post_ack", cpu_ack | vga_ack, 1'b0);
    chk1("post_owner", grant_vga, exp_v);
  endtask

  initial begin
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    vga_req = 1'b0; vga_addr = '0;
    cpu_rd_m = '0; vga_rd_m = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle after reset release: everything stays zero.
    repeat (10) begin
      @(negedge clk);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_outs", |{cpu_rdata, cpu_ack, vga_rdata, vga_ack, mem_en, mem_we,
                         mem_addr, mem_wdata, grant_vga}, 1'b0);
    end

    // CPU write of BEEF to 0040, then VGA reads it back.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 16'hBEEF;
    access(1'b1);
    vga_req = 1'b1; vga_addr = 16'h0040;
    access(1'b1);
    chk16("vga_beef", vga_rdata, 16'hBEEF);

    // CPU read of a location that holds 1234.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0123;
    access(1'b1);
    chk16("cpu_1234", cpu_rdata, 16'h1234);

    // Both held continuously: V,V,V,V,C repeating.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0200; cpu_wdata = 16'hC0DE;
    vga_req = 1'b1; vga_addr = 16'h0300;
    for (int i = 0; i < 10; i++) begin
      access(1'b0);
      chk1("starve_order", grant_vga, (i % 5) != 4);
    end
    cpu_req = 1'b0; vga_req = 1'b0;
    repeat (2) @(negedge clk);

    // Simultaneous request after a VGA access made with the CPU idle.
    vga_req = 1'b1; vga_addr = 16'h0200;
    access(1'b1);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0300;
    vga_req = 1'b1; vga_addr = 16'h0040;
    access(1'b1);
    chk1("tie_first_vga", grant_vga, 1'b1);
    access(1'b1);
    chk1("tie_then_cpu", grant_vga, 1'b0);

    // Randomized traffic against the model.
    for (int it = 0; it < 60; it++) begin
      if (!cpu_req && $urandom_range(0, 1) != 0) begin
        cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = pick_addr(); cpu_wdata = 16'($urandom);
      end
      if (!vga_req && $urandom_range(0, 1) != 0) begin
        vga_req = 1'b1; vga_addr = pick_addr();
      end
      if (!cpu_req && !vga_req) begin
        vga_req = 1'b1; vga_addr = pick_addr();
      end
      access($urandom_range(0, 3) != 0);
    end
    cpu_req = 1'b0; vga_req = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during the WAIT of a CPU read aborts it.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = pick_addr();
    @(negedge clk);
    chk1("abort_issue", mem_en, 1'b1);
    @(negedge clk);
    chk1("abort_wait_busy", busy, 1'b1);
    reset = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_en", mem_en, 1'b0);
    chk1("abort_ack", cpu_ack, 1'b0);
    chk16("abort_rdata", cpu_rdata, 16'h0000);
    reset = 1'b0;
    cpu_rd_m = '0; vga_rd_m = '0; starve_m = 0;
    repeat (4) begin
      @(negedge clk);
      chk1("abort_no_ack", cpu_ack | vga_ack, 1'b0);
    end
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0777; cpu_wdata = 16'h5AA5;
    access(1'b1);
    cpu_req = 1'b1; cpu_we = 1'b0;
    access(1'b1);
    chk16("fresh_read", cpu_rdata, 16'h5AA5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
